id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the MIPS datapath; drives the 32-bit ALU (slices of alu_1bit) directly.
//  Latches decoded operands and control from ID and applies EX/MEM and MEM/WB result forwarding.
//  Produces the ALU a/b/op/cin inputs and detects load-use hazards.
//  Valid/ready handshake on both sides supports multi-cycle EX ops and pipeline flush.
// PARAMETERS
//  WORD_W     32  datapath width (ALU operand width)
//  REG_ADDR_W 5   register-file address width
// PORTS
//  clk            in  1        rising-edge clock
//  rst_n          in  1        synchronous reset, active-low
//  flush          in  1        squash the held entry (branch/exception)
//  id_valid       in  1        ID presents an instruction
//  id_ready       out 1        stage accepts the ID instruction this cycle
//  id_rs, id_rt   in  REG_ADDR_W  source register numbers
//  id_rd          in  REG_ADDR_W  destination register number
//  id_rs_data     in  WORD_W   register-file read data, rs
//  id_rt_data     in  WORD_W   register-file read data, rt
//  id_imm         in  WORD_W   sign-extended immediate
//  id_alu_op      in  3        ALU op, mips_pkg encoding
//  id_alusrc      in  1        1: b operand = immediate
//  id_regwrite    in  1        instruction writes rd
//  id_memread     in  1        instruction is a load
//  ex_valid       out 1        held entry valid toward EX
//  ex_ready       in  1        EX consumes the entry this cycle
//  ex_a, ex_b     out WORD_W   ALU operands (after forwarding/alusrc)
//  ex_alu_op      out 3        ALU op
//  ex_cin         out 1        ALU carry-in; 1 when ex_alu_op == ALU_SUB
//  ex_rd          out REG_ADDR_W  destination passed down
//  ex_regwrite, ex_memread out 1  control passed down
//  exmem_regwrite/exmem_rd/exmem_result  in 1/REG_ADDR_W/WORD_W  EX/MEM writeback info
//  memwb_regwrite/memwb_rd/memwb_result  in 1/REG_ADDR_W/WORD_W  MEM/WB writeback info
//  hazard_stall   out 1        stall request to IF/ID
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): ex_valid=0; all held fields 0; hence ex_a=ex_b=0, ex_alu_op=0, ex_cin=0,
//    ex_rd=0, ex_regwrite=ex_memread=0. Reset mid-transfer drops the entry; no partial state survives.
//  - Single entry, latency 1: fields captured at posedge when id_valid && id_ready.
//  - id_ready = (!ex_valid || ex_ready) && !hazard_stall && !flush.
//  - Next ex_valid: flush -> 0; else capture -> 1; else ex_ready -> 0 (bubble); else hold.
//  - flush and id_valid same cycle: flush wins, entry not captured, ex_valid=0 next cycle.
//  - Held entry is stable while ex_valid && !ex_ready (all outputs constant except via forwarding).
//  - Forwarding (combinational on held rs/rt each cycle): EX/MEM match beats MEM/WB match;
//    match = *_regwrite && *_rd == held reg && held reg != 0. Register 0 never forwarded.
//  - ex_b = held alusrc ? held imm : forwarded rt value. ex_cin = (ex_alu_op == ALU_SUB).
//  - Load-use: hazard_stall = id_valid && ex_valid && ex_memread && ex_rd != 0 &&
//    (ex_rd == id_rs || ex_rd == id_rt). Stalled cycle: nothing captured; bubble inserted when EX drains.
//  - No arithmetic in this stage; widths pass unchanged, no truncation.
// CONFIGURATION
//  ID_EX_FORWARD_EN defined: forwarding as above; hazard_stall only on load-use.
//  Undefined: ex_a/ex_b use held register-file data only; exmem_*/memwb_* used only for hazard
//    detection: hazard_stall also asserts when id_rs/id_rt (nonzero) matches a writing exmem_rd or
//    memwb_rd, or a writing valid ex_rd.
// STRUCTURE
//  mips_pkg: WORD_W, REG_ADDR_W, ALU op localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT).
//  Sub-module fwd_mux: one held register number + data in, EX/MEM and MEM/WB info in,
//    forwarded word out; instantiated twice (rs, rt).
// TESTING
//  1 rst_n=0 two cycles with id_valid=1 -> ex_valid=0, all outputs 0, no capture.
//  2 id: rs=1 (data 5), rt=2 (data 7), op=ALU_ADD, id_valid=1, ex_ready=1 -> next cycle ex_a=5,
//    ex_b=7, ex_cin=0, ex_valid=1.
//  3 held rs=3; exmem_rd=3 result 0x11 and memwb_rd=3 result 0x22, both regwrite -> ex_a=0x11
//    (FORWARD_EN); rd=0 match with result 0xFF -> ex_a keeps register-file value.
//  4 held load ex_rd=4, ex_memread=1; id_rs=4, id_valid=1 -> hazard_stall=1, id_ready=0;
//    after ex_ready, ex_valid=0 one cycle, then instruction captured.
//  5 ex_ready=0 for 3 cycles with id_valid=1 -> outputs held, id_ready=0; then flush=1 with id_valid=1
//    -> ex_valid=0 next cycle, new ID entry not captured.
//  6 op=ALU_SUB, alusrc=1, imm=0xFFFFFFFC -> ex_b=0xFFFFFFFC, ex_cin=1.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths, ALU op encodings and the ID/EX entry
// record used by the ID/EX pipeline stage and its forwarding muxes.
//   WORD_W      datapath / ALU operand width
//   REG_ADDR_W  register-file address width
//   ALU_*       3-bit ALU op codes consumed by the alu_1bit slices
//   id_ex_entry_t  everything the stage holds for one instruction
//   reg_match() true when a writeback stage targets a given nonzero register
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 3;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_W-1:0]     rs_data;
    logic [WORD_W-1:0]     rt_data;
    logic [WORD_W-1:0]     imm;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  alusrc;
    logic                  regwrite;
    logic                  memread;
  } id_ex_entry_t;

  // Register 0 is hard-wired to zero, so a write to it never produces a match.
  function automatic logic reg_match(input logic                  wr_en,
                                     input logic [REG_ADDR_W-1:0] wr_rd,
                                     input logic [REG_ADDR_W-1:0] rd_reg);
    return wr_en && (wr_rd == rd_reg) && (rd_reg != '0);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: all non-clock signals of the ID/EX pipeline stage.
//   ID side      : id_valid/id_ready handshake, decoded operands and control
//   EX side      : ex_valid/ex_ready handshake, ALU a/b/op/cin and control
//   writeback    : exmem_* and memwb_* result info for forwarding / hazards
//   control      : flush in, hazard_stall out
// Modports: slave = the stage itself, master = whoever drives ID/EX/WB.
interface id_ex_stage_if;
  import mips_pkg::*;

  logic                  flush;
  logic                  id_valid;
  logic                  id_ready;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [WORD_W-1:0]     id_rs_data;
  logic [WORD_W-1:0]     id_rt_data;
  logic [WORD_W-1:0]     id_imm;
  logic [ALU_OP_W-1:0]   id_alu_op;
  logic                  id_alusrc;
  logic                  id_regwrite;
  logic                  id_memread;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [WORD_W-1:0]     ex_a;
  logic [WORD_W-1:0]     ex_b;
  logic [ALU_OP_W-1:0]   ex_alu_op;
  logic                  ex_cin;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_regwrite;
  logic                  ex_memread;

  logic                  exmem_regwrite;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [WORD_W-1:0]     exmem_result;
  logic                  memwb_regwrite;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [WORD_W-1:0]     memwb_result;

  logic                  hazard_stall;

  modport slave (
    input  flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_alu_op, id_alusrc, id_regwrite, id_memread,
           ex_ready,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    output id_ready, ex_valid, ex_a, ex_b, ex_alu_op, ex_cin, ex_rd,
           ex_regwrite, ex_memread, hazard_stall
  );

  modport master (
    output flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_alu_op, id_alusrc, id_regwrite, id_memread,
           ex_ready,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    input  id_ready, ex_valid, ex_a, ex_b, ex_alu_op, ex_cin, ex_rd,
           ex_regwrite, ex_memread, hazard_stall
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks the freshest value of one held source register.
//   reg_num / reg_data           held register number and its register-file data
//   exmem_regwrite/rd/result     EX/MEM writeback info (highest priority)
//   memwb_regwrite/rd/result     MEM/WB writeback info
//   fwd_data                     forwarded word (reg_data when nothing matches)
// Holding both *_regwrite low turns the mux into a plain pass-through.
module fwd_mux
  import mips_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] reg_num,
  input  logic [WORD_W-1:0]     reg_data,
  input  logic                  exmem_regwrite,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [WORD_W-1:0]     exmem_result,
  input  logic                  memwb_regwrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [WORD_W-1:0]     memwb_result,
  output logic [WORD_W-1:0]     fwd_data
);

  // EX/MEM is the younger producer, so it overrides MEM/WB.
  always_comb begin
    fwd_data = reg_data;
    if (reg_match(exmem_regwrite, exmem_rd, reg_num)) begin
      fwd_data = exmem_result;
    end else if (reg_match(memwb_regwrite, memwb_rd, reg_num)) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the MIPS datapath.
// Holds one decoded instruction, forwards EX/MEM and MEM/WB results onto the
// rs/rt operands, applies alusrc, and drives the 32-bit ALU (a, b, op, cin).
// Detects load-use hazards and stalls ID through hazard_stall.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low
//   bus    id_ex_stage_if.slave (ID handshake/operands, EX handshake/ALU
//          inputs, writeback info, flush, hazard_stall)
// Build option: define ID_EX_FORWARD_EN to enable result forwarding; when it
// is undefined the operands come straight from the register file and any
// pending write to a source register stalls ID instead.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

`ifdef ID_EX_FORWARD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  logic         valid_reg;
  logic         valid_next;
  id_ex_entry_t entry_reg;
  id_ex_entry_t entry_next;
  logic         capture;
  logic         load_use;
  logic         stall;

  // Load-use: the held load's result is not available until after MEM.
  assign load_use = bus.id_valid && valid_reg && entry_reg.memread &&
                    (entry_reg.rd != '0) &&
                    ((entry_reg.rd == bus.id_rs) || (entry_reg.rd == bus.id_rt));

`ifdef ID_EX_FORWARD_EN
  assign stall = load_use;
`else
  // Without forwarding, any in-flight write to a source register must retire
  // before the instruction can read the register file.
  logic rs_busy;
  logic rt_busy;

  assign rs_busy = reg_match(bus.exmem_regwrite, bus.exmem_rd, bus.id_rs) ||
                   reg_match(bus.memwb_regwrite, bus.memwb_rd, bus.id_rs) ||
                   (valid_reg && reg_match(entry_reg.regwrite, entry_reg.rd, bus.id_rs));
  assign rt_busy = reg_match(bus.exmem_regwrite, bus.exmem_rd, bus.id_rt) ||
                   reg_match(bus.memwb_regwrite, bus.memwb_rd, bus.id_rt) ||
                   (valid_reg && reg_match(entry_reg.regwrite, entry_reg.rd, bus.id_rt));
  assign stall   = load_use || (bus.id_valid && (rs_busy || rt_busy));
`endif

  assign bus.hazard_stall = stall;
  assign bus.id_ready     = (!valid_reg || bus.ex_ready) && !stall && !bus.flush;
  assign capture          = bus.id_valid && bus.id_ready;

  always_comb begin
    entry_next = entry_reg;
    valid_next = valid_reg;
    if (capture) begin
      entry_next.rs       = bus.id_rs;
      entry_next.rt       = bus.id_rt;
      entry_next.rd       = bus.id_rd;
      entry_next.rs_data  = bus.id_rs_data;
      entry_next.rt_data  = bus.id_rt_data;
      entry_next.imm      = bus.id_imm;
      entry_next.alu_op   = bus.id_alu_op;
      entry_next.alusrc   = bus.id_alusrc;
      entry_next.regwrite = bus.id_regwrite;
      entry_next.memread  = bus.id_memread;
    end
    // flush blocks capture through id_ready, so it also wins over id_valid.
    if (bus.flush) begin
      valid_next = 1'b0;
    end else if (capture) begin
      valid_next = 1'b1;
    end else if (bus.ex_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      entry_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      entry_reg <= entry_next;
    end
  end

  // Operand forwarding: index 0 = rs (ALU a), index 1 = rt (ALU b source).
  logic [REG_ADDR_W-1:0] held_reg  [2];
  logic [WORD_W-1:0]     held_data [2];
  logic [WORD_W-1:0]     fwd_data  [2];

  assign held_reg[0]  = entry_reg.rs;
  assign held_reg[1]  = entry_reg.rt;
  assign held_data[0] = entry_reg.rs_data;
  assign held_data[1] = entry_reg.rt_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_mux u_fwd_mux (
        .reg_num        (held_reg[gi]),
        .reg_data       (held_data[gi]),
        .exmem_regwrite (bus.exmem_regwrite & FWD_EN),
        .exmem_rd       (bus.exmem_rd),
        .exmem_result   (bus.exmem_result),
        .memwb_regwrite (bus.memwb_regwrite & FWD_EN),
        .memwb_rd       (bus.memwb_rd),
        .memwb_result   (bus.memwb_result),
        .fwd_data       (fwd_data[gi])
      );
    end
  endgenerate

  assign bus.ex_valid    = valid_reg;
  assign bus.ex_a        = fwd_data[0];
  assign bus.ex_b        = entry_reg.alusrc ? entry_reg.imm : fwd_data[1];
  assign bus.ex_alu_op   = entry_reg.alu_op;
  // Subtraction is a + ~b + 1 in the ripple ALU; the inversion lives in EX.
  assign bus.ex_cin      = (entry_reg.alu_op == ALU_SUB);
  assign bus.ex_rd       = entry_reg.rd;
  assign bus.ex_regwrite = entry_reg.regwrite;
  assign bus.ex_memread  = entry_reg.memread;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed, table-driven bench for id_ex_stage, plus a
// hand-written sequence for forwarding priority and the stall sources.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        rst_n, id_valid, flush, ex_ready;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [2:0]  op;
    logic        alusrc, regwrite, memread;
    logic        e_valid;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_op;
    logic        e_cin;
    logic [4:0]  e_rd;
    logic        e_memread, e_ready, e_stall;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, iv, fl, er, input logic [4:0] rs, rt, rd,
    input logic [31:0] rsd, rtd, imm, input logic [2:0] op,
    input logic as, rw, mr,
    input logic ev, input logic [31:0] ea, eb, input logic [2:0] eop,
    input logic ec, input logic [4:0] erd, input logic emr, erdy, est);
    vec_t v;
    v.rst_n = r; v.id_valid = iv; v.flush = fl; v.ex_ready = er;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.rs_data = rsd; v.rt_data = rtd; v.imm = imm; v.op = op;
    v.alusrc = as; v.regwrite = rw; v.memread = mr;
    v.e_valid = ev; v.e_a = ea; v.e_b = eb; v.e_op = eop; v.e_cin = ec;
    v.e_rd = erd; v.e_memread = emr; v.e_ready = erdy; v.e_stall = est;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n            = v.rst_n;
    bus.id_valid     = v.id_valid;
    bus.flush        = v.flush;
    bus.ex_ready     = v.ex_ready;
    bus.id_rs        = v.rs;
    bus.id_rt        = v.rt;
    bus.id_rd        = v.rd;
    bus.id_rs_data   = v.rs_data;
    bus.id_rt_data   = v.rt_data;
    bus.id_imm       = v.imm;
    bus.id_alu_op    = v.op;
    bus.id_alusrc    = v.alusrc;
    bus.id_regwrite  = v.regwrite;
    bus.id_memread   = v.memread;
  endtask

  vec_t vecs [16];

  initial begin
    // Inputs are applied on a falling edge; expectations describe the state
    // after the next rising edge with the same inputs still applied.
    vecs[0]  = mk(0,1,0,1, 1,2,5, 32'h5,32'h7,32'h0, ALU_ADD,0,1,0,
                  0,32'h0,32'h0,3'd0,0,5'd0,0, 1,0);
    vecs[1]  = vecs[0];
    vecs[2]  = mk(1,1,0,1, 1,2,5, 32'h5,32'h7,32'h0, ALU_ADD,0,1,0,
                  1,32'h5,32'h7,ALU_ADD,0,5'd5,0, 1,0);
    vecs[3]  = mk(1,1,0,1, 6,7,8, 32'h100,32'h200,32'hFFFFFFFC, ALU_SUB,1,1,0,
                  1,32'h100,32'hFFFFFFFC,ALU_SUB,1,5'd8,0, 1,0);
    vecs[4]  = mk(1,1,0,1, 9,10,4, 32'h40,32'h33,32'h10, ALU_ADD,1,1,1,
                  1,32'h40,32'h10,ALU_ADD,0,5'd4,1, 1,0);
    vecs[5]  = mk(1,1,0,0, 4,11,12, 32'hAAA,32'hBBB,32'h0, ALU_OR,0,1,0,
                  1,32'h40,32'h10,ALU_ADD,0,5'd4,1, 0,1);
    vecs[6]  = mk(1,1,0,1, 4,11,12, 32'hAAA,32'hBBB,32'h0, ALU_OR,0,1,0,
                  0,32'h40,32'h10,ALU_ADD,0,5'd4,1, 1,0);
    vecs[7]  = mk(1,1,0,1, 4,11,12, 32'hAAA,32'hBBB,32'h0, ALU_OR,0,1,0,
                  1,32'hAAA,32'hBBB,ALU_OR,0,5'd12,0, 1,0);
    vecs[8]  = mk(1,1,0,0, 13,14,15, 32'h1313,32'h1414,32'h0, ALU_AND,0,1,0,
                  1,32'hAAA,32'hBBB,ALU_OR,0,5'd12,0, 0,0);
    vecs[9]  = vecs[8];
    vecs[10] = vecs[8];
    vecs[11] = mk(1,1,1,0, 13,14,15, 32'h1313,32'h1414,32'h0, ALU_AND,0,1,0,
                  0,32'hAAA,32'hBBB,ALU_OR,0,5'd12,0, 0,0);
    vecs[12] = mk(1,0,0,1, 13,14,15, 32'h1313,32'h1414,32'h0, ALU_AND,0,1,0,
                  0,32'hAAA,32'hBBB,ALU_OR,0,5'd12,0, 1,0);
    vecs[13] = mk(1,1,0,0, 13,14,15, 32'h1313,32'h1414,32'h0, ALU_SUB,0,1,0,
                  1,32'h1313,32'h1414,ALU_SUB,1,5'd15,0, 0,0);
    vecs[14] = mk(0,0,0,0, 13,14,15, 32'h1313,32'h1414,32'h0, ALU_SUB,0,1,0,
                  0,32'h0,32'h0,3'd0,0,5'd0,0, 1,0);
    vecs[15] = mk(1,0,0,0, 13,14,15, 32'h1313,32'h1414,32'h0, ALU_SUB,0,1,0,
                  0,32'h0,32'h0,3'd0,0,5'd0,0, 1,0);

    rst_n              = 1'b0;
    bus.flush          = 1'b0;
    bus.id_valid       = 1'b0;
    bus.ex_ready       = 1'b0;
    bus.id_rs          = '0;
    bus.id_rt          = '0;
    bus.id_rd          = '0;
    bus.id_rs_data     = '0;
    bus.id_rt_data     = '0;
    bus.id_imm         = '0;
    bus.id_alu_op      = '0;
    bus.id_alusrc      = 1'b0;
    bus.id_regwrite    = 1'b0;
    bus.id_memread     = 1'b0;
    bus.exmem_regwrite = 1'b0;
    bus.exmem_rd       = '0;
    bus.exmem_result   = '0;
    bus.memwb_regwrite = 1'b0;
    bus.memwb_rd       = '0;
    bus.memwb_result   = '0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d ex_a", i), bus.ex_a, vecs[i].e_a);
      chk($sformatf("v%0d ex_b", i), bus.ex_b, vecs[i].e_b);
      chk($sformatf("v%0d ex_alu_op", i), {29'd0, bus.ex_alu_op}, {29'd0, vecs[i].e_op});
      chk($sformatf("v%0d ex_cin", i), {31'd0, bus.ex_cin}, {31'd0, vecs[i].e_cin});
      chk($sformatf("v%0d ex_rd", i), {27'd0, bus.ex_rd}, {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d ex_memread", i), {31'd0, bus.ex_memread}, {31'd0, vecs[i].e_memread});
      chk($sformatf("v%0d id_ready", i), {31'd0, bus.id_ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("v%0d hazard_stall", i), {31'd0, bus.hazard_stall}, {31'd0, vecs[i].e_stall});
      $display("vec %0d: valid=%0d a=%08h b=%08h op=%0d cin=%0d rd=%0d ready=%0d stall=%0d",
               i, bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_alu_op, bus.ex_cin,
               bus.ex_rd, bus.id_ready, bus.hazard_stall);
    end

    // Forwarding priority and register 0: hold rs=3, rt=0.
    @(negedge clk);
    rst_n = 1'b1; bus.flush = 1'b0; bus.id_valid = 1'b1; bus.ex_ready = 1'b1;
    bus.id_rs = 5'd3; bus.id_rt = 5'd0; bus.id_rd = 5'd16;
    bus.id_rs_data = 32'h33; bus.id_rt_data = 32'h44; bus.id_imm = 32'h0;
    bus.id_alu_op = ALU_ADD; bus.id_alusrc = 1'b0;
    bus.id_regwrite = 1'b1; bus.id_memread = 1'b0;
    @(posedge clk);
    #1;
    chk("fwd capture ex_a", bus.ex_a, 32'h33);
    chk("fwd capture ex_b", bus.ex_b, 32'h44);
    $display("seq capture: a=%08h b=%08h", bus.ex_a, bus.ex_b);

    @(negedge clk);
    bus.id_valid = 1'b0; bus.ex_ready = 1'b0;
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h11;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'h22;
    #1;
    chk("fwd exmem over memwb", bus.ex_a, FWD ? 32'h11 : 32'h33);
    $display("seq fwd both: a=%08h", bus.ex_a);
    bus.exmem_regwrite = 1'b0;
    #1;
    chk("fwd memwb only", bus.ex_a, FWD ? 32'h22 : 32'h33);
    $display("seq fwd memwb: a=%08h", bus.ex_a);
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hFF;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hEE;
    #1;
    chk("fwd rd0 ex_a", bus.ex_a, 32'h33);
    chk("fwd rd0 ex_b", bus.ex_b, 32'h44);
    $display("seq fwd rd0: a=%08h b=%08h", bus.ex_a, bus.ex_b);
    bus.exmem_regwrite = 1'b0; bus.memwb_regwrite = 1'b0;

    // Stall sources other than load-use (held entry: rd=16, regwrite, no load).
    @(negedge clk);
    bus.id_valid = 1'b1; bus.ex_ready = 1'b1;
    bus.id_rs = 5'd3; bus.id_rt = 5'd0;
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd3;
    #1;
    chk("stall exmem", {31'd0, bus.hazard_stall}, {31'd0, !FWD});
    chk("ready exmem", {31'd0, bus.id_ready}, {31'd0, FWD});
    $display("seq exmem: stall=%0d ready=%0d", bus.hazard_stall, bus.id_ready);
    bus.exmem_regwrite = 1'b0;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd3;
    #1;
    chk("stall memwb", {31'd0, bus.hazard_stall}, {31'd0, !FWD});
    $display("seq memwb: stall=%0d", bus.hazard_stall);
    bus.memwb_regwrite = 1'b0;
    bus.id_rs = 5'd16;
    #1;
    chk("stall ex_rd", {31'd0, bus.hazard_stall}, {31'd0, !FWD});
    $display("seq ex_rd: stall=%0d", bus.hazard_stall);
    bus.id_valid = 1'b0; bus.ex_ready = 1'b0;
    #1;
    chk("stall idle", {31'd0, bus.hazard_stall}, 32'd0);
    $display("seq idle: stall=%0d", bus.hazard_stall);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
